// File: rtl/mmio_tx_hub.sv
// Memory-mapped IO responder for the 0xF region: a sticky halt register plus
// CHANNELS FIFO-buffered byte TX streams. Optional 64-bit cycle counter under MMIO_CYCLE_EN.
module mmio_tx_hub #(
   parameter int          CHANNELS = 2,
   parameter int          DEPTH    = 16,
   parameter logic [3:0]  BASE     = 4'hf
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           mem_addr,
   input  logic                  mem_oe,
   input  logic [3:0]            mem_we,
   input  logic [31:0]           mem_wdata,
   output logic [31:0]           mmio_rdata,
   output logic                  mmio_ready,
   output logic                  halt,
   output logic [CHANNELS*8-1:0] tx_data,
   output logic [CHANNELS-1:0]   tx_valid,
   input  logic [CHANNELS-1:0]   tx_ready
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic        sel, wr, rd;
   logic [11:0] off;
   logic [31:0] rd_val;

   logic [CHANNELS-1:0]    data_hit, stat_hit, ovf_all;
   logic [CHANNELS*CW-1:0] cnt_n_all;

   assign off = mem_addr[11:0];
   assign sel = mem_oe && (mem_addr[31:28] == BASE);
   assign wr  = sel && (mem_we != 4'b0000);
   assign rd  = sel && (mem_we == 4'b0000);

   logic unused_bits;
   assign unused_bits = ^{mem_addr[27:12], mem_addr[1:0], mem_wdata[31:8]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         halt <= 1'b0;
      end else if (wr && (off[11:2] == 10'd0)) begin
         halt <= 1'b1;
      end
   end

   // Stream handshake: a byte transfers on every clock where tx_valid[c] and
   // tx_ready[c] are both high; tx_data[c] holds the FIFO head and stays put
   // while tx_valid[c]=1 and tx_ready[c]=0.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [7:0]    mem [DEPTH];
      logic [PW-1:0] wr_ptr, rd_ptr;
      logic [CW-1:0] count_q, count_n;
      logic          valid_q, ovf_q;
      logic          pop, push_req, push_ok;

      assign data_hit[c] = (off[11:3] == 9'(c + 2)) && !off[2];
      assign stat_hit[c] = (off[11:3] == 9'(c + 2)) &&  off[2];

      assign pop      = valid_q && tx_ready[c];
      assign push_req = wr && data_hit[c] && mem_we[0];
      // A full FIFO still takes a byte when the head leaves in the same cycle.
      assign push_ok  = push_req && ((count_q != DEPTH_C) || pop);

      always_comb begin
         count_n = count_q;
         if (push_ok && !pop) begin
            count_n = count_q + 1'b1;
         end else if (!push_ok && pop) begin
            count_n = count_q - 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_n;
            valid_q <= (count_n != '0);
            if (push_req && !push_ok) begin
               ovf_q <= 1'b1;
            end else if (wr && stat_hit[c]) begin
               ovf_q <= 1'b0;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst && push_ok) begin
            mem[wr_ptr] <= mem_wdata[7:0];
         end
      end

      assign tx_data[8*c +: 8]        = valid_q ? mem[rd_ptr] : 8'h00;
      assign tx_valid[c]              = valid_q;
      assign ovf_all[c]               = ovf_q;
      assign cnt_n_all[CW*c +: CW]    = count_n;
   end

`ifdef MMIO_CYCLE_EN
   logic [63:0] cyc;
   logic [31:0] cyc_hi;

   // Reading the low word snapshots the high word so the pair is tear-free.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cyc    <= '0;
         cyc_hi <= '0;
      end else begin
         cyc <= cyc + 64'd1;
         if (rd && (off[11:2] == 10'd2)) begin
            cyc_hi <= cyc[63:32];
         end
      end
   end
`endif

   always_comb begin
      rd_val = '0;
      if (off[11:2] == 10'd0) begin
         rd_val = {31'b0, halt};
      end
`ifdef MMIO_CYCLE_EN
      if (off[11:2] == 10'd2) rd_val = cyc[31:0];
      if (off[11:2] == 10'd3) rd_val = cyc_hi;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
         if (data_hit[i]) begin
            rd_val = 32'(DEPTH_C - cnt_n_all[CW*i +: CW]);
         end
         if (stat_hit[i]) begin
            rd_val = {16'(cnt_n_all[CW*i +: CW]), 13'b0, ovf_all[i],
                      (cnt_n_all[CW*i +: CW] == DEPTH_C),
                      (cnt_n_all[CW*i +: CW] == '0)};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mmio_ready <= 1'b0;
         mmio_rdata <= '0;
      end else begin
         mmio_ready <= rd;
         mmio_rdata <= rd ? rd_val : 32'h0;
      end
   end

endmodule

// File: tb/tb_mmio_tx_hub.sv
// Bench for mmio_tx_hub: queue-based reference model, per-cycle compare and
// directed register/stream scenarios with literal expectations.
module tb_mmio_tx_hub;

   localparam int CH    = 2;
   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [31:0]     mem_addr = '0;
   logic            mem_oe = 1'b0;
   logic [3:0]      mem_we = '0;
   logic [31:0]     mem_wdata = '0;
   logic [31:0]     mmio_rdata;
   logic            mmio_ready;
   logic            halt;
   logic [CH*8-1:0] tx_data;
   logic [CH-1:0]   tx_valid;
   logic [CH-1:0]   tx_ready = '0;

   int total = 0;
   int bad   = 0;
   logic started = 1'b0;

   mmio_tx_hub #(.CHANNELS(CH), .DEPTH(DEPTH), .BASE(4'hf)) dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_oe(mem_oe),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mmio_rdata(mmio_rdata),
      .mmio_ready(mmio_ready), .halt(halt), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // reference model
   logic [7:0]  m_q [CH][$];
   logic [31:0] exp_q [$];
   logic [CH-1:0] m_ovf;
   logic        m_halt;
   logic [63:0] m_cyc;
   logic [31:0] m_shadow;

   always @(posedge clk) begin : model
      logic [11:0] o;
      int          ch;
      logic [31:0] v;
      logic        s;
      if (!rst) begin
         for (int c = 0; c < CH; c++) m_q[c].delete();
         exp_q.delete();
         m_ovf = '0; m_halt = 1'b0; m_cyc = '0; m_shadow = '0;
      end else begin
         o = mem_addr[11:0] & 12'hffc;
         s = mem_oe && (mem_addr[31:28] == 4'hf);
         for (int c = 0; c < CH; c++)
            if (m_q[c].size() != 0 && tx_ready[c]) void'(m_q[c].pop_front());
         if (s && mem_we != 0) begin
            if (o == 0) m_halt = 1'b1;
            if (o >= 16 && o < 16 + 8*CH) begin
               ch = (int'(o) - 16) / 8;
               if ((int'(o) - 16) % 8 == 0) begin
                  if (mem_we[0]) begin
                     if (m_q[ch].size() < DEPTH) m_q[ch].push_back(mem_wdata[7:0]);
                     else m_ovf[ch] = 1'b1;
                  end
               end else begin
                  m_ovf[ch] = 1'b0;
               end
            end
         end
         if (s && mem_we == 0) begin
            v = 0;
            if (o == 0) v = {31'b0, m_halt};
`ifdef MMIO_CYCLE_EN
            if (o == 8) begin v = m_cyc[31:0]; m_shadow = m_cyc[63:32]; end
            if (o == 12) v = m_shadow;
`endif
            if (o >= 16 && o < 16 + 8*CH) begin
               ch = (int'(o) - 16) / 8;
               if ((int'(o) - 16) % 8 == 0) v = DEPTH - m_q[ch].size();
               else v = (m_q[ch].size() << 16) | ({29'b0, m_ovf[ch], 2'b00})
                        | ((m_q[ch].size() == DEPTH) ? 2 : 0) | ((m_q[ch].size() == 0) ? 1 : 0);
            end
            exp_q.push_back(v);
         end
         m_cyc = m_cyc + 1;
      end
   end

   // scoreboard: compare every cycle
   always @(negedge clk) begin
      if (started) begin
         check("ready", {31'b0, mmio_ready}, {31'b0, exp_q.size() != 0});
         if (exp_q.size() != 0) check("rdata", mmio_rdata, exp_q.pop_front());
         else check("rdata_idle", mmio_rdata, 32'h0);
         check("halt", {31'b0, halt}, {31'b0, m_halt});
         for (int c = 0; c < CH; c++) begin
            check("tx_valid", {31'b0, tx_valid[c]}, {31'b0, m_q[c].size() != 0});
            if (m_q[c].size() != 0) check("tx_data", {24'b0, tx_data[8*c +: 8]}, {24'b0, m_q[c][0]});
         end
      end
   end

   // driver tasks, entered just after a falling edge
   task automatic do_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
      mem_addr = a; mem_we = we; mem_wdata = d; mem_oe = 1'b1;
      @(negedge clk);
      mem_oe = 1'b0; mem_we = '0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d);
      mem_addr = a; mem_we = '0; mem_oe = 1'b1;
      @(negedge clk);
      mem_oe = 1'b0;
      d = mmio_rdata;
      check("rd_latency", {31'b0, mmio_ready}, 32'h1);
   endtask

   task automatic drain(input int c, output logic [7:0] got [$]);
      got.delete();
      tx_ready[c] = 1'b1;
      for (int k = 0; k < 40 && tx_valid[c]; k++) begin
         got.push_back(tx_data[8*c +: 8]);
         @(negedge clk);
      end
      tx_ready[c] = 1'b0;
      check("drain_done", {31'b0, tx_valid[c]}, 32'h0);
   endtask

   initial begin
      logic [31:0] d, d2;
      logic [7:0]  got [$];
      @(posedge clk);
      started = 1'b1;
      @(negedge clk);
      check("rst_ready", {31'b0, mmio_ready}, 32'h0);
      check("rst_rdata", mmio_rdata, 32'h0);
      check("rst_halt", {31'b0, halt}, 32'h0);
      check("rst_valid", {30'b0, tx_valid}, 32'h0);
      rst = 1'b1;

      do_write(32'hF000_0000, 4'hF, 32'h1);
      check("halt_set", {31'b0, halt}, 32'h1);
      do_read(32'hF000_0000, d);
      check("halt_rd", d, 32'h1);

      do_write(32'hF000_0010, 4'h1, 32'h41);
      do_write(32'hF000_0010, 4'h1, 32'h42);
      do_write(32'hF000_0010, 4'h1, 32'h43);
      check("tx0_head", {24'b0, tx_data[7:0]}, 32'h41);
      do_read(32'hF000_0014, d);
      check("st0_three", d, 32'h0003_0000);
      do_read(32'hF000_0010, d);
      check("free0", d, 32'd13);

      for (int j = 0; j < 17; j++) do_write(32'hF000_0018, 4'h1, 32'h10 + j);
      do_read(32'hF000_001C, d);
      check("st1_ovf_full", d, 32'h0010_0006);
      do_write(32'hF000_001C, 4'h2, 32'h0);
      do_read(32'hF000_001C, d);
      check("st1_ovf_clr", d, 32'h0010_0002);
      do_read(32'hF000_0018, d);
      check("free1_zero", d, 32'd0);

      tx_ready[1] = 1'b1;
      do_write(32'hF000_0018, 4'h1, 32'h99);
      tx_ready[1] = 1'b0;
      do_read(32'hF000_001C, d);
      check("st1_full_pop", d, 32'h0010_0002);
      drain(1, got);
      check("drain1_len", got.size(), 32'd16);
      if (got.size() == 16) begin
         check("drain1_first", {24'b0, got[0]}, 32'h11);
         check("drain1_wrap", {24'b0, got[14]}, 32'h1F);
         check("drain1_last", {24'b0, got[15]}, 32'h99);
      end
      drain(0, got);
      check("drain0_len", got.size(), 32'd3);
      if (got.size() == 3) check("drain0_order", {8'b0, got[0], got[1], got[2]}, 32'h0041_4243);

      tx_ready[0] = 1'b1;
      do_write(32'hF000_0010, 4'h1, 32'h55);
      check("empty_push_valid", {31'b0, tx_valid[0]}, 32'h1);
      check("empty_push_data", {24'b0, tx_data[7:0]}, 32'h55);
      @(negedge clk);
      tx_ready[0] = 1'b0;
      check("empty_push_gone", {31'b0, tx_valid[0]}, 32'h0);

      do_read(32'hF000_0ABC, d);
      check("unmapped", d, 32'h0);
      do_read(32'hF000_0000, d);
      check("b2b_1", d, 32'h1);
      do_read(32'hF000_0014, d);
      check("b2b_2", d, 32'h1);
      do_read(32'hF000_0ABC, d);
      check("b2b_3", d, 32'h0);

      do_write(32'hF000_0020, 4'h1, 32'h77);
      do_read(32'hF000_0024, d);
      check("oor_chan", d, 32'h0);
      check("oor_no_push", {30'b0, tx_valid}, 32'h0);
      do_read(32'hF000_0017, d);
      check("misaligned", d, 32'h1);

      mem_addr = 32'hE000_0000; mem_we = '0; mem_oe = 1'b1;
      @(negedge clk);
      mem_oe = 1'b0;
      check("other_base", {31'b0, mmio_ready}, 32'h0);

      do_read(32'hF000_0008, d);
      do_read(32'hF000_000C, d2);
`ifndef MMIO_CYCLE_EN
      check("cyc_lo_off", d, 32'h0);
      check("cyc_hi_off", d2, 32'h0);
`endif

      do_write(32'hF000_0018, 4'h1, 32'hA1);
      do_write(32'hF000_0018, 4'h1, 32'hA2);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_valid", {30'b0, tx_valid}, 32'h0);
      check("midrst_halt", {31'b0, halt}, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      do_read(32'hF000_001C, d);
      check("midrst_status", d, 32'h1);
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
